// File: rtl/hazard_unit_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_unit_mdu_pkg
// Brief  : Shared forward-select codes and MDU tracker state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package hazard_unit_mdu_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mduState_e;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_mdu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : mdu_scoreboard
// Brief  : Tracks an in-flight fixed-latency multiply/divide operation.
// Rev    : 1.0  initial release
// ============================================================================
module mdu_scoreboard
  import hazard_unit_mdu_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MduStartE,
  input  logic MduAbort,
  output logic MduBusy
);

  localparam int CW = $clog2(MDU_LAT + 1);
  localparam logic [CW-1:0] c_lat = CW'(MDU_LAT);
  localparam logic [CW-1:0] c_one = CW'(1);

  mduState_e     r_state;
  logic [CW-1:0] r_cnt;

  // An issue while busy is blocked upstream by the stall logic, so it is ignored here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      MduBusy <= 1'b0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (MduStartE && !MduAbort) begin
            r_state <= MDU_BUSY;
            r_cnt   <= c_lat;
            MduBusy <= 1'b1;
          end
        end
        MDU_BUSY: begin
          if (MduAbort || (r_cnt == c_one)) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            MduBusy <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - c_one;
          end
        end
        default: begin
          r_state <= MDU_IDLE;
          r_cnt   <= '0;
          MduBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit_mdu.sv
`default_nettype none
// ============================================================================
// Module : hazard_unit_mdu
// Brief  : 5-stage pipeline hazard unit with forwarding, interlocks and MDU tracking.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_unit_mdu
  import hazard_unit_mdu_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MDU_LAT     = 32,
  parameter bit BRANCH_IN_D = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              MduStartE,
  input  logic              MduStartD,
  input  logic              MduReadD,
  input  logic              MduAbort,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [1:0]        ForwardAD,
  output logic [1:0]        ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MduBusy
);

  // M has the newer value, so it wins over W; register 0 never forwards.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wrM,
    input logic              rwM,
    input logic [REG_AW-1:0] wrW,
    input logic              rwW
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (rwM && (src == wrM))      sel = FWD_MEM;
      else if (rwW && (src == wrW)) sel = FWD_WB;
    end
    return sel;
  endfunction

  logic w_lwStall;
  logic w_branchStall;
  logic w_mduStall;
  logic w_stall;

  assign ForwardAE = fwdSel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardBE = fwdSel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);

  generate
    if (BRANCH_IN_D) begin : g_branchInD
      logic w_hitE;
      logic w_hitM;
      assign ForwardAD = fwdSel(RsD, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      assign ForwardBD = fwdSel(RtD, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      assign w_hitE = RegWriteE && (WriteRegE != '0) && ((RsD == WriteRegE) || (RtD == WriteRegE));
      assign w_hitM = MemtoRegM && (WriteRegM != '0) && ((RsD == WriteRegM) || (RtD == WriteRegM));
      assign w_branchStall = BranchD && (w_hitE || w_hitM);
    end else begin : g_branchInE
      logic w_unused;
      assign ForwardAD     = FWD_RF;
      assign ForwardBD     = FWD_RF;
      assign w_branchStall = 1'b0;
      assign w_unused      = &{1'b0, BranchD, MemtoRegM, RegWriteE, WriteRegE};
    end
  endgenerate

  assign w_lwStall  = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));
  assign w_mduStall = (MduReadD || MduStartD) && (MduBusy || MduStartE);
  assign w_stall    = w_lwStall | w_branchStall | w_mduStall;

  assign StallF = w_stall;
  assign StallD = w_stall;
  assign FlushE = w_stall;

  mdu_scoreboard #(
    .MDU_LAT (MDU_LAT)
  ) u_mduScoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .MduStartE (MduStartE),
    .MduAbort  (MduAbort),
    .MduBusy   (MduBusy)
  );

endmodule
`default_nettype wire
